// File: rtl/map_access_arbiter_if.sv
// Client-side request bus and map RAM port of the map access arbiter.
// The slave modport is the arbiter; master is the environment.
interface map_access_arbiter_if #(
    parameter int NCLIENTS = 4
);
    logic [NCLIENTS-1:0]    req;
    logic [12*NCLIENTS-1:0] position_bus;
    logic [NCLIENTS-1:0]    write_bus;
    logic [8*NCLIENTS-1:0]  sprite_write_bus;
    logic [NCLIENTS-1:0]    ready;
    logic [7:0]             sprite_read;
    logic                   busy;
    logic [11:0]            map_addr;
    logic                   map_we;
    logic                   map_re;
    logic [7:0]             map_wdata;
    logic [7:0]             map_rdata;

    modport slave (
        input  req, position_bus, write_bus, sprite_write_bus, map_rdata,
        output ready, sprite_read, busy, map_addr, map_we, map_re, map_wdata
    );

    modport master (
        output req, position_bus, write_bus, sprite_write_bus, map_rdata,
        input  ready, sprite_read, busy, map_addr, map_we, map_re, map_wdata
    );
endinterface

// File: rtl/map_access_arbiter.sv
// Round-robin arbiter serialising game-object accesses onto the
// single tile-map RAM port.
module map_access_arbiter #(
    parameter int NCLIENTS   = 4,
    parameter int RD_LATENCY = 1
) (
    input logic                 clk,
    input logic                 reset,
    map_access_arbiter_if.slave bus
);
    localparam int IW = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;
    localparam int CW = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    state_t         state;
    state_t         state_nx;
    logic [IW-1:0]  rr;
    logic [IW-1:0]  win;
    logic [IW-1:0]  pick;
    logic           found;
    logic           wr;
    logic [CW-1:0]  cnt;
    logic [11:0]    addr_q;
    logic [7:0]     wdata_q;
    logic [7:0]     rdata_q;

    // Descending scan so the lowest offset from rr wins.
    always_comb begin
        pick  = rr;
        found = 1'b0;
        for (int k = NCLIENTS - 1; k >= 0; k--) begin
            if (bus.req[(int'(rr) + k) % NCLIENTS]) begin
                pick  = IW'((int'(rr) + k) % NCLIENTS);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (found) state_nx = ISSUE;
            ISSUE:   state_nx = wr ? DONE : WAIT_RD;
            WAIT_RD: if (cnt == CW'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = '0;
        if (state == DONE) bus.ready[win] = 1'b1;
    end

    assign bus.map_we      = (state == ISSUE) && wr;
    assign bus.map_re      = (state == ISSUE) && !wr;
    assign bus.busy        = (state != IDLE);
    assign bus.map_addr    = addr_q;
    assign bus.map_wdata   = wdata_q;
    assign bus.sprite_read = rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rr      <= '0;
            win     <= '0;
            wr      <= 1'b0;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        win    <= pick;
                        addr_q <= bus.position_bus[12*int'(pick) +: 12];
                        wr     <= bus.write_bus[pick];
                        if (bus.write_bus[pick])
                            wdata_q <= bus.sprite_write_bus[8*int'(pick) +: 8];
                    end
                end
                ISSUE: cnt <= CW'(RD_LATENCY);
                WAIT_RD: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) rdata_q <= bus.map_rdata;
                end
                DONE: rr <= (win == IW'(NCLIENTS - 1)) ? '0 : win + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_map_access_arbiter.sv
// Self-checking bench for map_access_arbiter with a behavioural
// map RAM and a transaction-level reference model.
module tb_map_access_arbiter;
    localparam int N = 4;
    localparam int L = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    map_access_arbiter_if #(.NCLIENTS(N)) bus ();

    map_access_arbiter #(.NCLIENTS(N), .RD_LATENCY(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    logic [N-1:0] reqv;
    logic [N-1:0] wr_d;
    logic [11:0]  pos_d  [N];
    logic [7:0]   code_d [N];
    logic [7:0]   ref_wr [int];

    function automatic logic [7:0] ram_init(logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]};
    endfunction

    function automatic logic [7:0] ref_read(logic [11:0] a);
        if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
        return ram_init(a);
    endfunction

    // Map RAM: data for a read appears L cycles after map_re.
    logic [7:0] mem [4096];
    logic [7:0] pd [L];
    logic       pv [L];
    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 4096; a++) mem[a] <= ram_init(12'(a));
        end else if (bus.map_we) begin
            mem[bus.map_addr] <= bus.map_wdata;
        end
        pd[0] <= mem[bus.map_addr];
        pv[0] <= bus.map_re;
        for (int i = 1; i < L; i++) begin
            pd[i] <= pd[i-1];
            pv[i] <= pv[i-1];
        end
    end
    assign bus.map_rdata = (pv[L-1] === 1'b1) ? pd[L-1] : 8'hEE;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.position_bus[12*i +: 12]    = pos_d[i];
            bus.sprite_write_bus[8*i +: 8]  = code_d[i];
        end
        bus.write_bus = wr_d;
        bus.req       = reqv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        reqv  = '0;
        wr_d  = '0;
        for (int i = 0; i < N; i++) begin
            pos_d[i]  = '0;
            code_d[i] = '0;
        end
        drive();
        tick();
        tick();
        reset = 1'b0;
        ref_wr.delete();
    endtask

    task automatic wait_ready(output logic [N-1:0] r, output int n);
        r = '0;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (bus.ready != '0) begin
                r = bus.ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reqv  = '1;
        drive();
        tick();
        checks++; if (bus.ready !== 4'b0) $display("FAIL rst_ready got=%b exp=0", bus.ready); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else passed++;
        checks++; if (bus.map_we !== 1'b0) $display("FAIL rst_we got=%b exp=0", bus.map_we); else passed++;
        checks++; if (bus.map_re !== 1'b0) $display("FAIL rst_re got=%b exp=0", bus.map_re); else passed++;
        checks++; if (bus.map_addr !== 12'h0) $display("FAIL rst_addr got=%h exp=0", bus.map_addr); else passed++;
        checks++; if (bus.map_wdata !== 8'h0) $display("FAIL rst_wdata got=%h exp=0", bus.map_wdata); else passed++;
        checks++; if (bus.sprite_read !== 8'h0) $display("FAIL rst_sread got=%h exp=0", bus.sprite_read); else passed++;
        do_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        pos_d[1]  = {6'd12, 6'd4};
        wr_d[1]   = 1'b1;
        code_d[1] = 8'h01;
        reqv      = 4'b0010;
        drive();
        tick();
        checks++; if (bus.map_we !== 1'b1) $display("FAIL wr_we got=%b exp=1", bus.map_we); else passed++;
        checks++; if (bus.map_re !== 1'b0) $display("FAIL wr_re got=%b exp=0", bus.map_re); else passed++;
        checks++; if (bus.map_addr !== 12'h304) $display("FAIL wr_addr got=%h exp=304", bus.map_addr); else passed++;
        checks++; if (bus.map_wdata !== 8'h01) $display("FAIL wr_wdata got=%h exp=01", bus.map_wdata); else passed++;
        tick();
        checks++; if (bus.ready !== 4'b0010) $display("FAIL wr_ready got=%b exp=0010", bus.ready); else passed++;
        checks++; if (bus.sprite_read !== 8'h00) $display("FAIL wr_sread got=%h exp=00", bus.sprite_read); else passed++;
        reqv = '0;
        drive();
        tick();
        checks++; if (bus.busy !== 1'b0) $display("FAIL wr_idle got=%b exp=0", bus.busy); else passed++;
    endtask

    task automatic test_single_read();
        logic [N-1:0] r;
        int n;
        pos_d[2]  = {6'd5, 6'd7};
        wr_d[2]   = 1'b1;
        code_d[2] = 8'h2A;
        reqv      = 4'b0100;
        drive();
        wait_ready(r, n);
        checks++; if (r !== 4'b0100) $display("FAIL rd_prewrite got=%b exp=0100", r); else passed++;
        reqv = '0;
        drive();
        tick();
        pos_d[0] = {6'd5, 6'd7};
        wr_d[0]  = 1'b0;
        reqv     = 4'b0001;
        drive();
        tick();
        checks++; if (bus.map_re !== 1'b1) $display("FAIL rd_re got=%b exp=1", bus.map_re); else passed++;
        checks++; if (bus.map_we !== 1'b0) $display("FAIL rd_we got=%b exp=0", bus.map_we); else passed++;
        checks++; if (bus.map_addr !== 12'h147) $display("FAIL rd_addr got=%h exp=147", bus.map_addr); else passed++;
        for (int k = 0; k < L; k++) begin
            tick();
            checks++; if (bus.ready !== 4'b0) $display("FAIL rd_early got=%b exp=0", bus.ready); else passed++;
        end
        tick();
        checks++; if (bus.ready !== 4'b0001) $display("FAIL rd_ready got=%b exp=0001", bus.ready); else passed++;
        checks++; if (bus.sprite_read !== 8'h2A) $display("FAIL rd_data got=%h exp=2a", bus.sprite_read); else passed++;
        reqv = '0;
        drive();
        tick();
    endtask

    task automatic test_all_four();
        int mrr = 0;
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            logic [N-1:0] pending;
            int got = 0;
            for (int i = 0; i < N; i++) begin
                pos_d[i]  = 12'($urandom);
                wr_d[i]   = 1'($urandom);
                code_d[i] = 8'($urandom);
            end
            reqv    = '1;
            pending = '1;
            drive();
            for (int c = 0; c < 60 && got < N; c++) begin
                tick();
                if (bus.ready != '0) begin
                    int w = -1;
                    logic [N-1:0] e = '0;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && pending[(mrr + k) % N]) w = (mrr + k) % N;
                    e[w] = 1'b1;
                    checks++; if (bus.ready !== e) $display("FAIL burst%0d_grant%0d got=%b exp=%b", rep, got, bus.ready, e); else passed++;
                    pending[w] = 1'b0;
                    mrr  = (w + 1) % N;
                    reqv = reqv & ~bus.ready;
                    drive();
                    got++;
                end
            end
            checks++; if (got !== N) $display("FAIL burst%0d_count got=%0d exp=%0d", rep, got, N); else passed++;
            tick();
        end
    endtask

    task automatic test_fairness();
        int exp_seq[4] = '{0, 2, 0, 2};
        int got = 0;
        do_reset();
        wr_d = '0;
        reqv = 4'b0101;
        drive();
        for (int c = 0; c < 40 && got < 4; c++) begin
            tick();
            if (bus.ready != '0) begin
                logic [N-1:0] e = '0;
                e[exp_seq[got]] = 1'b1;
                checks++; if (bus.ready !== e) $display("FAIL fair%0d got=%b exp=%b", got, bus.ready, e); else passed++;
                got++;
            end
        end
        checks++; if (got !== 4) $display("FAIL fair_count got=%0d exp=4", got); else passed++;
        reqv = '0;
        drive();
        tick();
        tick();
    endtask

    task automatic test_reset_in_wait();
        logic [N-1:0] r;
        int n;
        int bad = 0;
        do_reset();
        pos_d[1] = 12'h0A5;
        wr_d[1]  = 1'b0;
        reqv     = 4'b0010;
        drive();
        wait_ready(r, n);
        checks++; if (bus.sprite_read !== 8'hA5) $display("FAIL rw_pre got=%h exp=a5", bus.sprite_read); else passed++;
        reqv = '0;
        drive();
        tick();
        pos_d[1] = 12'h3C1;
        reqv     = 4'b0010;
        drive();
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++; if (bus.ready !== 4'b0) $display("FAIL rw_ready got=%b exp=0", bus.ready); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rw_busy got=%b exp=0", bus.busy); else passed++;
        checks++; if (bus.map_addr !== 12'h0) $display("FAIL rw_addr got=%h exp=0", bus.map_addr); else passed++;
        checks++; if (bus.sprite_read !== 8'h0) $display("FAIL rw_sread got=%h exp=0", bus.sprite_read); else passed++;
        reqv = '0;
        drive();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.ready !== 4'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL rw_after bad_cycles=%0d exp=0", bad); else passed++;
    endtask

    task automatic test_drop_in_issue();
        logic [N-1:0] r;
        int n;
        logic [11:0] p;
        logic [7:0] c;
        do_reset();
        p = 12'($urandom);
        c = 8'($urandom);
        pos_d[3]  = p;
        code_d[3] = c;
        wr_d[3]   = 1'b1;
        reqv      = 4'b1000;
        drive();
        tick();
        checks++; if (bus.map_we !== 1'b1) $display("FAIL drop_we got=%b exp=1", bus.map_we); else passed++;
        checks++; if (bus.map_addr !== p) $display("FAIL drop_addr got=%h exp=%h", bus.map_addr, p); else passed++;
        checks++; if (bus.map_wdata !== c) $display("FAIL drop_wdata got=%h exp=%h", bus.map_wdata, c); else passed++;
        reqv      = '0;
        pos_d[3]  = ~p;
        code_d[3] = ~c;
        drive();
        tick();
        checks++; if (bus.ready !== 4'b1000) $display("FAIL drop_ready got=%b exp=1000", bus.ready); else passed++;
        tick();
        pos_d[3] = p;
        wr_d[3]  = 1'b0;
        reqv     = 4'b1000;
        drive();
        wait_ready(r, n);
        checks++; if (r !== 4'b1000) $display("FAIL drop_rb_ready got=%b exp=1000", r); else passed++;
        checks++; if (bus.sprite_read !== c) $display("FAIL drop_rb_data got=%h exp=%h", bus.sprite_read, c); else passed++;
        reqv = '0;
        drive();
        tick();
    endtask

    task automatic test_random();
        int cstate[N];
        logic [N-1:0] exp_r;
        logic [11:0] m_pos;
        logic [7:0] m_code;
        logic [7:0] m_sprite;
        logic m_wr;
        logic act;
        int m_win, m_rr, m_issue, m_ready, m_free;
        do_reset();
        m_rr = 0; m_sprite = '0; act = 1'b0; m_free = 0;
        m_issue = -1; m_ready = -1; m_win = 0; m_wr = 1'b0;
        m_pos = '0; m_code = '0;
        for (int i = 0; i < N; i++) cstate[i] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            exp_r = '0;
            if (act && cyc == m_ready) begin
                exp_r[m_win] = 1'b1;
                if (!m_wr) m_sprite = ref_read(m_pos);
            end
            checks++; if (bus.ready !== exp_r) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.ready, exp_r); else passed++;
            checks++; if (bus.busy !== act) $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, act); else passed++;
            checks++; if (bus.map_we !== (act && cyc == m_issue && m_wr)) $display("FAIL rnd_we cyc=%0d got=%b", cyc, bus.map_we); else passed++;
            checks++; if (bus.map_re !== (act && cyc == m_issue && !m_wr)) $display("FAIL rnd_re cyc=%0d got=%b", cyc, bus.map_re); else passed++;
            checks++; if (bus.sprite_read !== m_sprite) $display("FAIL rnd_sread cyc=%0d got=%h exp=%h", cyc, bus.sprite_read, m_sprite); else passed++;
            if (act) begin
                checks++; if (bus.map_addr !== m_pos) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, bus.map_addr, m_pos); else passed++;
                if (m_wr) begin
                    checks++; if (bus.map_wdata !== m_code) $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, bus.map_wdata, m_code); else passed++;
                end
            end
            if (act && cyc == m_ready) begin
                act = 1'b0;
                cstate[m_win] = 0;
                reqv[m_win] = 1'b0;
                if (m_wr) ref_wr[int'(m_pos)] = m_code;
            end
            for (int i = 0; i < N; i++) begin
                if (cstate[i] == 0 && $urandom_range(0, 2) == 0) begin
                    cstate[i] = 1;
                    pos_d[i]  = 12'($urandom);
                    wr_d[i]   = 1'($urandom);
                    code_d[i] = 8'($urandom);
                    reqv[i]   = 1'b1;
                end else if (cstate[i] == 2 && $urandom_range(0, 3) == 0) begin
                    pos_d[i]  = 12'($urandom);
                    wr_d[i]   = 1'($urandom);
                    code_d[i] = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) reqv[i] = 1'b0;
                end
            end
            if (!act && cyc >= m_free && reqv != '0) begin
                m_win = -1;
                for (int k = 0; k < N; k++)
                    if (m_win < 0 && reqv[(m_rr + k) % N]) m_win = (m_rr + k) % N;
                m_pos   = pos_d[m_win];
                m_wr    = wr_d[m_win];
                m_code  = code_d[m_win];
                m_issue = cyc + 1;
                m_ready = cyc + 2 + (m_wr ? 0 : L);
                m_free  = m_ready + 1;
                act     = 1'b1;
                cstate[m_win] = 2;
                m_rr    = (m_win + 1) % N;
            end
            drive();
            tick();
        end
        reqv = '0;
        drive();
        tick();
        tick();
    endtask

    initial begin
        reqv = '0;
        wr_d = '0;
        for (int i = 0; i < N; i++) begin
            pos_d[i]  = '0;
            code_d[i] = '0;
        end
        drive();
        test_reset();
        test_single_write();
        test_single_read();
        test_all_four();
        test_fairness();
        test_reset_in_wait();
        test_drop_in_issue();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/map_access_arbiter.md
Name: map_access_arbiter

Overview:
- Sits directly downstream of the game-object modules (pacman, blinky and the other ghosts). Consumes their position / sprite_write / write requests and drives the single tile-map RAM port.
- Serialises requests with round-robin arbitration. Returns read data and a one-cycle ready pulse to the granted object.
- Lets all object FSMs share one map port without collisions.

Parameters:
- NCLIENTS, 4, number of object clients (fixed at 4 for arbitration-order tests).
- RD_LATENCY, 1, map RAM read latency in clk cycles (1..3).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- req  input  NCLIENTS  per-client access request; level, held until ready
- position_bus  input  12*NCLIENTS  client i position {x[5:0],y[5:0]} at bits [12i+11:12i]
- write_bus  input  NCLIENTS  client i: 1 = write, 0 = read
- sprite_write_bus  input  8*NCLIENTS  client i write sprite code at bits [8i+7:8i]
- ready  output  NCLIENTS  one-hot, one-cycle completion pulse to the granted client
- sprite_read  output  8  shared read data; valid while ready[i] is high for a read
- busy  output  1  high whenever the FSM is not in IDLE
- map_addr  output  12  map RAM address
- map_we  output  1  map RAM write enable
- map_re  output  1  map RAM read enable
- map_wdata  output  8  map RAM write data
- map_rdata  input  8  map RAM read data, valid RD_LATENCY cycles after the map_re cycle

Behaviour:
Reset (async, any state):
- State returns to IDLE; rr pointer = 0.
- ready, map_we, map_re, busy, map_addr, map_wdata and sprite_read all go to 0.
- Any in-flight transaction is discarded; no ready is issued for it.

FSM states: IDLE, ISSUE, WAIT_RD, DONE.

IDLE:
- If any req bit is set, select the winner.
- Winner = first set bit searching from rr pointer upward, wrapping modulo NCLIENTS.
- Latch winner index, position, write bit and sprite code into internal registers; go to ISSUE.
- With no req, stay in IDLE.

ISSUE (exactly one cycle):
- map_addr = latched position.
- Write: map_we = 1 with map_wdata = latched sprite code; next state DONE.
- Read: map_re = 1; next state WAIT_RD with wait counter = RD_LATENCY.

WAIT_RD:
- Decrement the counter each cycle.
- In the cycle the counter reaches 1, map_rdata is valid and is registered into sprite_read at that edge; go to DONE.

DONE (one cycle):
- ready[winner] = 1.
- rr pointer = (winner + 1) mod NCLIENTS.
- Next state IDLE.

Strobes and hold behaviour:
- map_we and map_re are high only in ISSUE. map_addr and map_wdata hold their last values otherwise.

Latency (req high at cycle 0, FSM in IDLE):
- Write: ISSUE in cycle 1, ready in cycle 2.
- Read: ISSUE in cycle 1, ready in cycle 2+RD_LATENCY (cycle 3 for RD_LATENCY = 1).

Request handling:
- Requests are latched. A client that drops req or changes its inputs after the IDLE grant cycle does not affect the transaction; ready still pulses.
- A client must drop req in the cycle after ready. If req is still high in the next IDLE, it is a new request, arbitrated with the advanced pointer.
- Arbitration happens only in IDLE, so simultaneous new requests during ISSUE, WAIT_RD or DONE are just waited for.

Data handling:
- sprite_read holds the last read value until the next read completes. Writes never change it.
- Position bits pass through unmodified; no range check is done (64x64 map address space).

Idle timing:
- Minimum spacing between transactions is one IDLE cycle.
- busy = 0 only in IDLE.

Test Plan:
- Single write: client 1 req, write=1, pos {6'd12,6'd4}, code 8'h01 → cycle 1: map_we=1, map_addr=12'h304, map_wdata=8'h01; cycle 2: ready=4'b0010. sprite_read unchanged.
- Single read, RD_LATENCY=1: client 0 reads pos {6'd5,6'd7}, RAM returns 8'h2A → map_re in cycle 1, ready=4'b0001 in cycle 3, sprite_read=8'h2A.
- All four clients request simultaneously and hold req until their ready → grant order 0,1,2,3, each ready exactly once. Repeating the burst gives order 0,1,2,3 again.
- Client 0 holds req continuously while client 2 requests → alternating grants 0,2,0,2 (rr fairness, no starvation).
- Reset asserted during WAIT_RD of a read → all outputs 0 immediately, no ready pulse. After release with no req, busy stays 0.
- Client 3 drops req in the ISSUE cycle of its write → write still performed with latched data, ready[3] pulses in cycle 2.
